// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states, latency.
package mdu_pkg;

  localparam int MDU_WIDTH   = 32;
  localparam int MDU_CNT_W   = 6;
  localparam int MDU_LATENCY = MDU_WIDTH + 3;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring divide step.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplier_nxt
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    // Divide: acc = {remainder, dividend/quotient}; divisor sits in mcand[WIDTH-1:0].
    trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff  = trial - {1'b0, mcand[WIDTH-1:0]};
    if (is_div) begin
      if (diff[WIDTH]) acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      // Multiply keeps the product right-aligned; the multiplicand walks left instead.
      if (mplier[0]) acc_nxt = acc + mcand;
      mcand_nxt  = {mcand[2*WIDTH-2:0], 1'b0};
      mplier_nxt = {1'b0, mplier[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller writing HI/LO; busy stalls the pipeline.
// Define MDU_EARLY_TERM_EN to end multiplies once the remaining multiplier bits are zero.
// Handshake: start is sampled only in IDLE/DONE while flush is low; done pulses once per
// accepted operation unless flush is high in that same cycle.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mdu_state_t       state_dbg
);

  mdu_state_t state, state_nxt;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               neg_q, rneg_q, dbz_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   res_hi, res_lo, hi_q, lo_q;

  logic [2*WIDTH-1:0] acc_step, mcand_step;
  logic [WIDTH-1:0]   mplier_step;
  logic               is_div, sign_a, sign_b, early_done;
  logic [WIDTH-1:0]   abs_a, abs_b;

  assign is_div = op_is_div(op_q);
  assign sign_a = op_is_signed(op_q) & a_q[WIDTH-1];
  assign sign_b = op_is_signed(op_q) & b_q[WIDTH-1];
  assign abs_a  = sign_a ? -a_q : a_q;
  assign abs_b  = sign_b ? -b_q : b_q;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div     (is_div),
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_nxt    (acc_step),
    .mcand_nxt  (mcand_step),
    .mplier_nxt (mplier_step)
  );

`ifdef MDU_EARLY_TERM_EN
  assign early_done = !is_div && (mplier_step == '0);
`else
  assign early_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_PREP;
      ST_PREP: state_nxt = (is_div && b_q == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt == CNT_W'(1) || early_done) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_PREP : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dbz_q  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      res_hi <= '0;
      res_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (state == ST_DONE && !flush) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if ((state == ST_IDLE || state == ST_DONE) && start && !flush) begin
        op_q <= op;
        a_q  <= srcA;
        b_q  <= srcB;
      end
      case (state)
        ST_PREP: begin
          neg_q  <= sign_a ^ sign_b;
          rneg_q <= sign_a;
          cnt    <= CNT_W'(WIDTH);
          mplier <= abs_b;
          dbz_q  <= is_div && (b_q == '0);
          if (is_div) begin
            acc   <= {{WIDTH{1'b0}}, abs_a};
            mcand <= {{WIDTH{1'b0}}, abs_b};
          end else begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, abs_a};
          end
          // Divide by zero skips the datapath and reports dividend / all-ones directly.
          res_hi <= a_q;
          res_lo <= '1;
        end
        ST_RUN: begin
          acc    <= acc_step;
          mcand  <= mcand_step;
          mplier <= mplier_step;
          cnt    <= cnt - CNT_W'(1);
        end
        ST_FIX: begin
          if (is_div) begin
            res_lo <= neg_q  ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
            res_hi <= rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end else begin
            {res_hi, res_lo} <= neg_q ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state == ST_PREP) || (state == ST_RUN) || (state == ST_FIX);
  assign done        = (state == ST_DONE) && !flush;
  assign div_by_zero = done && dbz_q;
  assign hi          = done ? res_hi : hi_q;
  assign lo          = done ? res_lo : lo_q;
  assign state_dbg   = state;

endmodule
